// File: rtl/status_flag_sequencer.sv
// Sequences every write into the CPU status-flag register and runs the PHP/PLP stack handshake.
// Define STATUS_SEQ_ID_FLAGS_EN to build the internal I and D flag registers.
module status_flag_sequencer #(
   parameter logic [1:0] PUSH_FIXED_BITS = 2'b11
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [1:0] cmd_flag,
   input  logic       cmd_value,
   input  logic [7:0] alu_result,
   input  logic [7:0] operand,
   input  logic       alu_carry,
   input  logic       alu_overflow,
   input  logic       flag_carry,
   input  logic       flag_zero,
   input  logic       flag_negative,
   input  logic       flag_overflow,
   output logic [7:0] sr_data,
   output logic       sr_update_carry,
   output logic       sr_update_zero,
   output logic       sr_update_negative,
   output logic       sr_update_overflow,
   output logic       sr_set_carry,
   output logic       sr_clear_carry,
   output logic       sr_set_overflow,
   output logic       sr_clear_overflow,
   output logic       sr_carry_in,
   output logic       sr_overflow_in,
   output logic       flag_irq_disable,
   output logic       flag_decimal,
   output logic       mem_req,
   output logic       mem_we,
   output logic [7:0] mem_wdata,
   input  logic       mem_ack,
   input  logic [7:0] mem_rdata,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_EXEC     = 3'd1,
      S_BIT_N    = 3'd2,
      S_PUSH     = 3'd3,
      S_PULL     = 3'd4,
      S_PULL_ZCV = 3'd5,
      S_PULL_N   = 3'd6
   } state_e;

   localparam logic [2:0] OP_NZ   = 3'b000;
   localparam logic [2:0] OP_NZC  = 3'b001;
   localparam logic [2:0] OP_NZCV = 3'b010;
   localparam logic [2:0] OP_FLAG = 3'b011;
   localparam logic [2:0] OP_BIT  = 3'b100;
   localparam logic [2:0] OP_PUSH = 3'b101;
   localparam logic [2:0] OP_PULL = 3'b110;

   typedef struct packed {
      logic [7:0] data;
      logic       upd_c;
      logic       upd_z;
      logic       upd_n;
      logic       upd_v;
      logic       set_c;
      logic       clr_c;
      logic       set_v;
      logic       clr_v;
      logic       c_in;
      logic       v_in;
      logic       req;
      logic       we;
      logic [7:0] wdata;
      logic       ready;
      logic       busy;
   } out_t;

   localparam out_t OUT_RESET = '{data: 8'h00, upd_c: 1'b0, upd_z: 1'b0, upd_n: 1'b0,
                                  upd_v: 1'b0, set_c: 1'b0, clr_c: 1'b0, set_v: 1'b0,
                                  clr_v: 1'b0, c_in: 1'b0, v_in: 1'b0, req: 1'b0,
                                  we: 1'b0, wdata: 8'h00, ready: 1'b1, busy: 1'b0};

   state_e     state_q, state_d;
   out_t       out_q, out_d;
   logic       accept_s;
   logic [2:0] op_q, op_d;
   logic [1:0] flag_q, flag_d;
   logic       value_q, value_d;
   logic [7:0] alu_q, alu_d;
   logic [7:0] opnd_q, opnd_d;
   logic       carry_q, carry_d;
   logic       ovf_q, ovf_d;
   logic [3:0] nvzc_q, nvzc_d;   // {N, V, Z, C} as seen at acceptance
   logic [7:0] pull_q, pull_d;
   logic       irq_s, dec_s;
   logic       unused_s;

   assign accept_s = (state_q == S_IDLE) && cmd_valid;

   // State and captured-command registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         out_q   <= OUT_RESET;
         op_q    <= 3'b000;
         flag_q  <= 2'b00;
         value_q <= 1'b0;
         alu_q   <= 8'h00;
         opnd_q  <= 8'h00;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         nvzc_q  <= 4'h0;
         pull_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         op_q    <= op_d;
         flag_q  <= flag_d;
         value_q <= value_d;
         alu_q   <= alu_d;
         opnd_q  <= opnd_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         nvzc_q  <= nvzc_d;
         pull_q  <= pull_d;
      end
   end

   // Inputs are sampled only on the accepting edge; the pulled byte only on its ack
   always_comb begin
      if (accept_s) begin
         op_d    = cmd_op;
         flag_d  = cmd_flag;
         value_d = cmd_value;
         alu_d   = alu_result;
         opnd_d  = operand;
         carry_d = alu_carry;
         ovf_d   = alu_overflow;
         nvzc_d  = {flag_negative, flag_overflow, flag_zero, flag_carry};
      end else begin
         op_d    = op_q;
         flag_d  = flag_q;
         value_d = value_q;
         alu_d   = alu_q;
         opnd_d  = opnd_q;
         carry_d = carry_q;
         ovf_d   = ovf_q;
         nvzc_d  = nvzc_q;
      end
      if ((state_q == S_PULL) && mem_ack) begin
         pull_d = mem_rdata;
      end else begin
         pull_d = pull_q;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_PUSH: state_d = S_PUSH;
                  OP_PULL: state_d = S_PULL;
                  default: state_d = S_EXEC;
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end
         S_EXEC:     state_d = (op_q == OP_BIT) ? S_BIT_N : S_IDLE;
         S_BIT_N:    state_d = S_IDLE;
         S_PUSH:     state_d = mem_ack ? S_IDLE : S_PUSH;
         S_PULL:     state_d = mem_ack ? S_PULL_ZCV : S_PULL;
         S_PULL_ZCV: state_d = S_PULL_N;
         S_PULL_N:   state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Outputs are computed for the state being entered so they appear registered
   always_comb begin
      out_d       = {$bits(out_t){1'b0}};
      out_d.ready = (state_d == S_IDLE);
      out_d.busy  = (state_d != S_IDLE);
      case (state_d)
         S_EXEC: begin
            case (op_d)
               OP_NZ, OP_NZC, OP_NZCV: begin
                  out_d.data  = alu_d;
                  out_d.upd_z = 1'b1;
                  out_d.upd_n = 1'b1;
                  out_d.upd_c = (op_d != OP_NZ);
                  out_d.c_in  = (op_d != OP_NZ) && carry_d;
                  out_d.upd_v = (op_d == OP_NZCV);
                  out_d.v_in  = (op_d == OP_NZCV) && ovf_d;
               end
               OP_FLAG: begin
                  case (flag_d)
                     2'b00: begin
                        out_d.set_c = value_d;
                        out_d.clr_c = ~value_d;
                     end
                     2'b11: begin
                        out_d.set_v = value_d;
                        out_d.clr_v = ~value_d;
                     end
                     default: out_d.data = 8'h00;
                  endcase
               end
               OP_BIT: begin
                  out_d.data  = alu_d;
                  out_d.upd_z = 1'b1;
                  out_d.upd_v = 1'b1;
                  out_d.v_in  = opnd_d[6];
               end
               default: out_d.data = 8'h00;
            endcase
         end
         S_BIT_N: begin
            out_d.data  = opnd_d;
            out_d.upd_n = 1'b1;
         end
         S_PUSH: begin
            out_d.req   = 1'b1;
            out_d.we    = 1'b1;
            out_d.wdata = {nvzc_d[3], nvzc_d[2], PUSH_FIXED_BITS, dec_s, irq_s, nvzc_d[1], nvzc_d[0]};
         end
         S_PULL: out_d.req = 1'b1;
         S_PULL_ZCV: begin
            out_d.data  = {7'b0000000, ~pull_d[1]};
            out_d.upd_z = 1'b1;
            out_d.upd_c = 1'b1;
            out_d.c_in  = pull_d[0];
            out_d.upd_v = 1'b1;
            out_d.v_in  = pull_d[6];
         end
         S_PULL_N: begin
            out_d.data  = {pull_d[7], 7'b0000000};
            out_d.upd_n = 1'b1;
         end
         default: out_d.data = 8'h00;
      endcase
   end

`ifdef STATUS_SEQ_ID_FLAGS_EN
   logic irq_q, dec_q;

   // I and D are written when a FLAG command leaves EXEC or a pull leaves PULL_ZCV
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q <= 1'b0;
         dec_q <= 1'b0;
      end else if ((state_q == S_EXEC) && (op_q == OP_FLAG) && (flag_q == 2'b01)) begin
         irq_q <= value_q;
      end else if ((state_q == S_EXEC) && (op_q == OP_FLAG) && (flag_q == 2'b10)) begin
         dec_q <= value_q;
      end else if (state_q == S_PULL_ZCV) begin
         irq_q <= pull_q[2];
         dec_q <= pull_q[3];
      end else begin
         irq_q <= irq_q;
         dec_q <= dec_q;
      end
   end

   assign irq_s    = irq_q;
   assign dec_s    = dec_q;
   assign unused_s = ^{pull_q[5:4]};
`else
   assign irq_s    = 1'b0;
   assign dec_s    = 1'b0;
   assign unused_s = ^{pull_q[5:2]};
`endif

   assign flag_irq_disable   = irq_s;
   assign flag_decimal       = dec_s;
   assign cmd_ready          = out_q.ready;
   assign busy               = out_q.busy;
   assign sr_data            = out_q.data;
   assign sr_update_carry    = out_q.upd_c;
   assign sr_update_zero     = out_q.upd_z;
   assign sr_update_negative = out_q.upd_n;
   assign sr_update_overflow = out_q.upd_v;
   assign sr_set_carry       = out_q.set_c;
   assign sr_clear_carry     = out_q.clr_c;
   assign sr_set_overflow    = out_q.set_v;
   assign sr_clear_overflow  = out_q.clr_v;
   assign sr_carry_in        = out_q.c_in;
   assign sr_overflow_in     = out_q.v_in;
   assign mem_req            = out_q.req;
   assign mem_we             = out_q.we;
   assign mem_wdata          = out_q.wdata;

endmodule

// File: tb/tb_status_flag_sequencer.sv
// Randomised self-checking bench for status_flag_sequencer; an external flag register is
// driven by the DUT strobes and compared against flag values computed from the command rules.
module tb_status_flag_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid, cmd_ready;
   logic [2:0] cmd_op;
   logic [1:0] cmd_flag;
   logic       cmd_value;
   logic [7:0] alu_result, operand;
   logic       alu_carry, alu_overflow;
   logic       flag_carry, flag_zero, flag_negative, flag_overflow;
   logic [7:0] sr_data;
   logic       sr_update_carry, sr_update_zero, sr_update_negative, sr_update_overflow;
   logic       sr_set_carry, sr_clear_carry, sr_set_overflow, sr_clear_overflow;
   logic       sr_carry_in, sr_overflow_in;
   logic       flag_irq_disable, flag_decimal;
   logic       mem_req, mem_we, mem_ack, busy;
   logic [7:0] mem_wdata, mem_rdata;

   localparam logic [7:0] UZ = 8'h80, UN = 8'h40, UC = 8'h20, UV = 8'h10;
   localparam logic [7:0] SC = 8'h08, CC = 8'h04, SO = 8'h02, CO = 8'h01;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural flag-register model, used as the expected values
   logic mc = 1'b0, mz = 1'b0, mn = 1'b0, mv = 1'b0, mi = 1'b0, md = 1'b0;

   // external flag register driven by the DUT strobes
   logic fr_init;
   logic fc, fz, fn, fv;

   always #5 clk = ~clk;

   status_flag_sequencer dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_flag(cmd_flag), .cmd_value(cmd_value),
      .alu_result(alu_result), .operand(operand), .alu_carry(alu_carry),
      .alu_overflow(alu_overflow), .flag_carry(flag_carry), .flag_zero(flag_zero),
      .flag_negative(flag_negative), .flag_overflow(flag_overflow), .sr_data(sr_data),
      .sr_update_carry(sr_update_carry), .sr_update_zero(sr_update_zero),
      .sr_update_negative(sr_update_negative), .sr_update_overflow(sr_update_overflow),
      .sr_set_carry(sr_set_carry), .sr_clear_carry(sr_clear_carry),
      .sr_set_overflow(sr_set_overflow), .sr_clear_overflow(sr_clear_overflow),
      .sr_carry_in(sr_carry_in), .sr_overflow_in(sr_overflow_in),
      .flag_irq_disable(flag_irq_disable), .flag_decimal(flag_decimal),
      .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always @(posedge clk) begin
      if (fr_init) begin
         fc <= 1'b0; fz <= 1'b0; fn <= 1'b0; fv <= 1'b0;
      end else begin
         if (sr_update_zero) fz <= (sr_data == 8'h00);
         if (sr_update_negative) fn <= sr_data[7];
         if (sr_update_carry) fc <= sr_carry_in;
         else if (sr_set_carry) fc <= 1'b1;
         else if (sr_clear_carry) fc <= 1'b0;
         if (sr_update_overflow) fv <= sr_overflow_in;
         else if (sr_set_overflow) fv <= 1'b1;
         else if (sr_clear_overflow) fv <= 1'b0;
      end
   end

   assign flag_carry    = fc;
   assign flag_zero     = fz;
   assign flag_negative = fn;
   assign flag_overflow = fv;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // {pad, data, strobes, c_in, v_in, req, we, wdata, ready, busy}
   function automatic logic [31:0] pk(input logic [7:0] d, input logic [7:0] stb, input logic ci,
                                      input logic oi, input logic rq, input logic we,
                                      input logic [7:0] wd, input logic rdy);
      return {2'b00, d, stb, ci, oi, rq, we, wd, rdy, ~rdy};
   endfunction

   function automatic logic [31:0] obs_vec();
      return {2'b00, sr_data, sr_update_zero, sr_update_negative, sr_update_carry,
              sr_update_overflow, sr_set_carry, sr_clear_carry, sr_set_overflow,
              sr_clear_overflow, sr_carry_in, sr_overflow_in, mem_req, mem_we, mem_wdata,
              cmd_ready, busy};
   endfunction

   // c_in/v_in matter only with their update strobe; we/wdata only while mem_req
   task automatic cmp_cycle(input string tag, input logic [31:0] e);
      logic [31:0] m;
      m = 32'hFFFF_FFFF;
      if (!e[19]) m[13] = 1'b0;
      if (!e[18]) m[12] = 1'b0;
      if (!e[11]) begin
         m[10]  = 1'b0;
         m[9:2] = 8'h00;
      end
      check_eq(tag, obs_vec() & m, e & m);
   endtask

   task automatic check_flags(input string tag);
      check_eq({tag, "_C"}, fc, mc);
      check_eq({tag, "_Z"}, fz, mz);
      check_eq({tag, "_N"}, fn, mn);
      check_eq({tag, "_V"}, fv, mv);
      check_eq({tag, "_I"}, flag_irq_disable, mi);
      check_eq({tag, "_D"}, flag_decimal, md);
   endtask

   task automatic run_cmd(input logic [2:0] op, input logic [1:0] fl, input logic val,
                          input logic [7:0] alu, input logic car, input logic ovf,
                          input logic [7:0] opd, input logic [7:0] rd, input int dly,
                          input logic hold);
      logic [31:0] exp_q[$];
      logic        ack_q[$];
      logic [7:0]  w;
      case (op)
         3'b000, 3'b001, 3'b010: begin
            exp_q.push_back(pk(alu, UZ | UN | ((op != 3'b000) ? UC : 8'h00) |
                               ((op == 3'b010) ? UV : 8'h00), car, ovf, 1'b0, 1'b0, 8'h00, 1'b0));
            ack_q.push_back(1'($urandom_range(0, 1)));
            mz = (alu == 8'h00);
            mn = alu[7];
            if (op != 3'b000) mc = car;
            if (op == 3'b010) mv = ovf;
         end
         3'b011: begin
            case (fl)
               2'b00: begin
                  exp_q.push_back(pk(8'h00, val ? SC : CC, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
                  mc = val;
               end
               2'b11: begin
                  exp_q.push_back(pk(8'h00, val ? SO : CO, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
                  mv = val;
               end
               default: begin
                  exp_q.push_back(pk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
`ifdef STATUS_SEQ_ID_FLAGS_EN
                  if (fl == 2'b01) mi = val;
                  else md = val;
`endif
               end
            endcase
            ack_q.push_back(1'($urandom_range(0, 1)));
         end
         3'b100: begin
            exp_q.push_back(pk(alu, UZ | UV, 1'b0, opd[6], 1'b0, 1'b0, 8'h00, 1'b0));
            exp_q.push_back(pk(opd, UN, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
            ack_q.push_back(1'($urandom_range(0, 1)));
            ack_q.push_back(1'($urandom_range(0, 1)));
            mz = (alu == 8'h00);
            mv = opd[6];
            mn = opd[7];
         end
         3'b101: begin
            w = {mn, mv, 2'b11, md, mi, mz, mc};
            for (int i = 0; i <= dly; i++) begin
               exp_q.push_back(pk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, w, 1'b0));
               ack_q.push_back(i == dly);
            end
         end
         3'b110: begin
            for (int i = 0; i <= dly; i++) begin
               exp_q.push_back(pk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0));
               ack_q.push_back(i == dly);
            end
            exp_q.push_back(pk({7'b0000000, ~rd[1]}, UZ | UC | UV, rd[0], rd[6], 1'b0, 1'b0,
                               8'h00, 1'b0));
            exp_q.push_back(pk({rd[7], 7'b0000000}, UN, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
            ack_q.push_back(1'($urandom_range(0, 1)));
            ack_q.push_back(1'($urandom_range(0, 1)));
            mc = rd[0];
            mz = rd[1];
            mv = rd[6];
            mn = rd[7];
`ifdef STATUS_SEQ_ID_FLAGS_EN
            mi = rd[2];
            md = rd[3];
`endif
         end
         default: begin
            exp_q.push_back(pk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
            ack_q.push_back(1'($urandom_range(0, 1)));
         end
      endcase
      exp_q.push_back(pk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1));
      ack_q.push_back(1'($urandom_range(0, 1)));

      check_eq("ready_before", cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_op = op; cmd_flag = fl; cmd_value = val;
      alu_result = alu; alu_carry = car; alu_overflow = ovf; operand = opd;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(posedge clk); #1;
         cmp_cycle($sformatf("op%0d_cyc%0d", op, i), exp_q[i]);
         cmd_valid  = (i == exp_q.size() - 1) ? 1'b0 : hold;
         cmd_op     = 3'($urandom);
         cmd_flag   = 2'($urandom);
         cmd_value  = 1'($urandom);
         alu_result = 8'($urandom);
         operand    = 8'($urandom);
         alu_carry  = 1'($urandom);
         alu_overflow = 1'($urandom);
         mem_ack    = ack_q[i];
         mem_rdata  = ack_q[i] ? rd : 8'($urandom);
      end
      check_flags($sformatf("op%0d_flags", op));
   endtask

   task automatic reset_during_pull();
      cmd_valid = 1'b1; cmd_op = 3'b110;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmp_cycle("rst_pull_req", pk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0));
      reset = 1'b1;
      @(posedge clk); #1;
      check_eq("rst_pull_reset", obs_vec(), pk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1));
      mi = 1'b0;
      md = 1'b0;
      reset = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hFF;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      check_eq("rst_late_ack", obs_vec(), pk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1));
      @(posedge clk); #1;
      check_eq("rst_after_ack", obs_vec(), pk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1));
      check_flags("rst_flags");
   endtask

   initial begin
      reset = 1'b1; fr_init = 1'b1;
      cmd_valid = 1'b0; cmd_op = 3'b111; cmd_flag = 2'b00; cmd_value = 1'b0;
      alu_result = 8'h00; operand = 8'h00; alu_carry = 1'b0; alu_overflow = 1'b0;
      mem_ack = 1'b0; mem_rdata = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_out", obs_vec(), pk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1));
      check_eq("reset_I", flag_irq_disable, 1'b0);
      check_eq("reset_D", flag_decimal, 1'b0);
      reset = 1'b0; fr_init = 1'b0;
      @(posedge clk); #1;

      run_cmd(3'b010, 2'b00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 8'h00, 0, 1'b0);
      run_cmd(3'b100, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hC0, 8'h00, 0, 1'b0);
      run_cmd(3'b011, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b0);
      run_cmd(3'b000, 2'b00, 1'b0, 8'h80, 1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b0);
      run_cmd(3'b101, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 3, 1'b1);
      run_cmd(3'b110, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'hC3, 0, 1'b0);
      run_cmd(3'b011, 2'b00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b1);
      run_cmd(3'b011, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b1);
      reset_during_pull();

      for (int k = 0; k < 150; k++) begin
         run_cmd(3'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
                 1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
